// File: rtl/cpu_bus_pkg.sv
// Shared constants and bus payload type for the CPU memory-bus arbiter.
package cpu_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
    } bus_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select; on a tie the port named by ptr wins.
module mem_arb_pick
    import cpu_bus_pkg::*;
(
    input  logic req_instr,
    input  logic req_data,
    input  logic ptr,
    output logic winner
);

    always_comb begin
        winner = OWNER_INSTR;
        if (req_instr && req_data) begin
            winner = ptr;
        end else if (req_data) begin
            winner = OWNER_DATA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one Avalon master bus.
// Optional MEM_BUS_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests.
module mem_bus_arbiter
    import cpu_bus_pkg::*;
(
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,

    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [BE_W-1:0]     d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,

    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [BE_W-1:0]     byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,

    output logic                busy,
    output logic                owner
);

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       owner_q;
    logic       owner_d;
    logic       req_instr;
    logic       req_data;
    logic       ptr;
    logic       winner;
    logic       grant;
    bus_req_t   instr_req;
    bus_req_t   data_req;
    bus_req_t   bus_c;

    assign req_instr = i_read;
    assign req_data  = d_read | d_write;

    // Instruction fetches are always full-word reads.
    always_comb begin
        instr_req            = '0;
        instr_req.address    = i_address;
        instr_req.read       = i_read;
        instr_req.byteenable = '1;
    end

    // A simultaneous read and write resolves to the write.
    always_comb begin
        data_req            = '0;
        data_req.address    = d_address;
        data_req.read       = d_read & ~d_write;
        data_req.write      = d_write;
        data_req.writedata  = d_writedata;
        data_req.byteenable = d_byteenable;
    end

    mem_arb_pick u_pick (
        .req_instr (req_instr),
        .req_data  (req_data),
        .ptr       (ptr),
        .winner    (winner)
    );

    assign grant = (state_q == ARB_IDLE) && (state_d == ARB_BUSY);

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    logic ptr_q;

    // Pointer names the port preferred on the next tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= OWNER_INSTR;
        end else if (grant) begin
            ptr_q <= ~winner;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = OWNER_DATA;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= OWNER_INSTR;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next state and bus mux; reset blanks the bus so an aborted transfer never completes.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        bus_c         = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;

        if (state_q == ARB_BUSY) begin
            if (owner_q == OWNER_DATA) begin
                bus_c         = data_req;
                d_waitrequest = waitrequest;
            end else begin
                bus_c         = instr_req;
                i_waitrequest = waitrequest;
            end
            if (!(bus_c.read || bus_c.write) || !waitrequest) begin
                state_d = ARB_IDLE;
            end
        end else if (req_instr || req_data) begin
            state_d = ARB_BUSY;
            owner_d = winner;
        end

        if (reset) begin
            bus_c         = '0;
            i_waitrequest = 1'b1;
            d_waitrequest = 1'b1;
        end
    end

    assign address    = bus_c.address;
    assign read       = bus_c.read;
    assign write      = bus_c.write;
    assign writedata  = bus_c.writedata;
    assign byteenable = bus_c.byteenable;

    assign i_readdata = readdata;
    assign d_readdata = readdata;

    assign busy  = (state_q == ARB_BUSY);
    assign owner = owner_q;

endmodule
